// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Purpose : Arbitrates icache/dcache onto one memory port, routes data by tag.
// Revision: 1.0 - initial release
// ============================================================================

package mem_arbiter_pkg;
    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } MEM_COMMAND;

    typedef logic [31:0] ADDR;
    typedef logic [63:0] MEM_BLOCK;
    typedef logic [3:0]  MEM_TAG;

    localparam int NUM_MEM_TAGS = 15;
endpackage

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_TAGS     = NUM_MEM_TAGS,
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  MEM_COMMAND Icache2mem_command,
    input  ADDR        Icache2mem_addr,
    input  MEM_COMMAND Dcache2mem_command,
    input  ADDR        Dcache2mem_addr,
    input  MEM_BLOCK   Dcache2mem_data,
    input  MEM_TAG     mem2proc_transaction_tag,
    input  MEM_BLOCK   mem2proc_data,
    input  MEM_TAG     mem2proc_data_tag,
    output MEM_COMMAND proc2mem_command,
    output ADDR        proc2mem_addr,
    output MEM_BLOCK   proc2mem_data,
    output MEM_TAG     mem2Icache_transaction_tag,
    output MEM_BLOCK   mem2Icache_data,
    output MEM_TAG     mem2Icache_data_tag,
    output MEM_TAG     mem2Dcache_transaction_tag,
    output MEM_BLOCK   mem2Dcache_data,
    output MEM_TAG     mem2Dcache_data_tag,
    output logic       dcache_request
);

    localparam int c_table_size = 2 ** $bits(MEM_TAG);
    localparam int c_cnt_w      = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_cnt_w-1:0] c_starve_max = c_cnt_w'(STARVE_LIMIT);

    logic [c_table_size-1:0] r_owner_valid;
    logic [c_table_size-1:0] r_owner_is_dcache;
    logic [c_cnt_w-1:0]      r_starve_cnt;

    logic       w_icache_active;
    logic       w_dcache_active;
    logic       w_grant_icache;
    logic       w_grant_dcache;
    MEM_COMMAND w_granted_cmd;
    logic       w_load_accept;
    logic       w_return_hit;
    logic       w_return_dcache;

    assign w_icache_active = (Icache2mem_command != MEM_NONE);
    assign w_dcache_active = (Dcache2mem_command != MEM_NONE);

    // icache wins only when alone or after losing STARVE_LIMIT times in a row
    assign w_grant_icache = w_icache_active &&
                            (!w_dcache_active || (r_starve_cnt == c_starve_max));
    assign w_grant_dcache = w_dcache_active && !w_grant_icache;

    assign w_granted_cmd = w_grant_dcache ? Dcache2mem_command :
                           w_grant_icache ? Icache2mem_command : MEM_NONE;

    assign w_load_accept = (w_granted_cmd == MEM_LOAD) &&
                           (mem2proc_transaction_tag != '0) &&
                           (int'(mem2proc_transaction_tag) <= NUM_TAGS);

    assign w_return_hit    = (mem2proc_data_tag != '0) && r_owner_valid[mem2proc_data_tag];
    assign w_return_dcache = r_owner_is_dcache[mem2proc_data_tag];

    always_comb begin
        proc2mem_command           = MEM_NONE;
        proc2mem_addr              = '0;
        proc2mem_data              = '0;
        mem2Icache_transaction_tag = '0;
        mem2Dcache_transaction_tag = '0;
        mem2Icache_data            = '0;
        mem2Dcache_data            = '0;
        mem2Icache_data_tag        = '0;
        mem2Dcache_data_tag        = '0;
        dcache_request             = 1'b0;
        if (!reset) begin
            proc2mem_command = w_granted_cmd;
            if (w_grant_dcache) begin
                proc2mem_addr              = Dcache2mem_addr;
                proc2mem_data              = Dcache2mem_data;
                mem2Dcache_transaction_tag = mem2proc_transaction_tag;
                dcache_request             = 1'b1;
            end else if (w_grant_icache) begin
                proc2mem_addr              = Icache2mem_addr;
                mem2Icache_transaction_tag = mem2proc_transaction_tag;
            end
            mem2Icache_data = mem2proc_data;
            mem2Dcache_data = mem2proc_data;
            if (w_return_hit) begin
                if (w_return_dcache) begin
                    mem2Dcache_data_tag = mem2proc_data_tag;
                end else begin
                    mem2Icache_data_tag = mem2proc_data_tag;
                end
            end
        end
    end

    // Allocation is written after the return clear so a same-tag set wins
    always_ff @(posedge clock) begin
        if (reset) begin
            r_owner_valid     <= '0;
            r_owner_is_dcache <= '0;
            r_starve_cnt      <= '0;
        end else begin
            if (w_return_hit) begin
                r_owner_valid[mem2proc_data_tag] <= 1'b0;
            end
            if (w_load_accept) begin
                r_owner_valid[mem2proc_transaction_tag]     <= 1'b1;
                r_owner_is_dcache[mem2proc_transaction_tag] <= w_grant_dcache;
            end
            if (w_icache_active && !w_grant_icache) begin
                if (r_starve_cnt != c_starve_max) begin
                    r_starve_cnt <= r_starve_cnt + 1'b1;
                end
            end else begin
                r_starve_cnt <= '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter
// Purpose : Self-checking bench for mem_arbiter against a tag/loss-count model.
// Revision: 1.0 - initial release
// ============================================================================

module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int STARVE_LIMIT = 4;

    logic       clock = 1'b0;
    logic       reset;
    MEM_COMMAND Icache2mem_command;
    ADDR        Icache2mem_addr;
    MEM_COMMAND Dcache2mem_command;
    ADDR        Dcache2mem_addr;
    MEM_BLOCK   Dcache2mem_data;
    MEM_TAG     mem2proc_transaction_tag;
    MEM_BLOCK   mem2proc_data;
    MEM_TAG     mem2proc_data_tag;
    MEM_COMMAND proc2mem_command;
    ADDR        proc2mem_addr;
    MEM_BLOCK   proc2mem_data;
    MEM_TAG     mem2Icache_transaction_tag;
    MEM_BLOCK   mem2Icache_data;
    MEM_TAG     mem2Icache_data_tag;
    MEM_TAG     mem2Dcache_transaction_tag;
    MEM_BLOCK   mem2Dcache_data;
    MEM_TAG     mem2Dcache_data_tag;
    logic       dcache_request;

    mem_arbiter #(.NUM_TAGS(15), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clock                      (clock),
        .reset                      (reset),
        .Icache2mem_command         (Icache2mem_command),
        .Icache2mem_addr            (Icache2mem_addr),
        .Dcache2mem_command         (Dcache2mem_command),
        .Dcache2mem_addr            (Dcache2mem_addr),
        .Dcache2mem_data            (Dcache2mem_data),
        .mem2proc_transaction_tag   (mem2proc_transaction_tag),
        .mem2proc_data              (mem2proc_data),
        .mem2proc_data_tag          (mem2proc_data_tag),
        .proc2mem_command           (proc2mem_command),
        .proc2mem_addr              (proc2mem_addr),
        .proc2mem_data              (proc2mem_data),
        .mem2Icache_transaction_tag (mem2Icache_transaction_tag),
        .mem2Icache_data            (mem2Icache_data),
        .mem2Icache_data_tag        (mem2Icache_data_tag),
        .mem2Dcache_transaction_tag (mem2Dcache_transaction_tag),
        .mem2Dcache_data            (mem2Dcache_data),
        .mem2Dcache_data_tag        (mem2Dcache_data_tag),
        .dcache_request             (dcache_request)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: owner per tag (-1 none, 0 icache, 1 dcache) and loss streak
    int m_owner [16];
    int m_losses;

    MEM_COMMAND e_cmd;
    ADDR        e_addr;
    MEM_BLOCK   e_pdata, e_data;
    MEM_TAG     e_itag, e_dtag, e_idtag, e_ddtag;
    logic       e_dreq, e_grant_i, e_grant_d, e_ret;

    task automatic model_eval();
        bit ia, da;
        e_cmd = MEM_NONE; e_addr = '0; e_pdata = '0; e_data = '0;
        e_itag = '0; e_dtag = '0; e_idtag = '0; e_ddtag = '0;
        e_dreq = 1'b0; e_grant_i = 1'b0; e_grant_d = 1'b0; e_ret = 1'b0;
        if (reset) return;
        ia = (Icache2mem_command != MEM_NONE);
        da = (Dcache2mem_command != MEM_NONE);
        if (ia && da) begin
            if (m_losses >= STARVE_LIMIT) e_grant_i = 1'b1;
            else                          e_grant_d = 1'b1;
        end else if (ia) begin
            e_grant_i = 1'b1;
        end else if (da) begin
            e_grant_d = 1'b1;
        end
        if (e_grant_d) begin
            e_cmd = Dcache2mem_command; e_addr = Dcache2mem_addr;
            e_pdata = Dcache2mem_data; e_dtag = mem2proc_transaction_tag; e_dreq = 1'b1;
        end else if (e_grant_i) begin
            e_cmd = Icache2mem_command; e_addr = Icache2mem_addr;
            e_itag = mem2proc_transaction_tag;
        end
        e_data = mem2proc_data;
        if (mem2proc_data_tag != 0 && m_owner[mem2proc_data_tag] != -1) begin
            e_ret = 1'b1;
            if (m_owner[mem2proc_data_tag] == 1) e_ddtag = mem2proc_data_tag;
            else                                 e_idtag = mem2proc_data_tag;
        end
    endtask

    task automatic model_commit();
        if (reset) begin
            foreach (m_owner[i]) m_owner[i] = -1;
            m_losses = 0;
            return;
        end
        model_eval();
        if (e_ret) m_owner[mem2proc_data_tag] = -1;
        if ((e_grant_i || e_grant_d) && e_cmd == MEM_LOAD && mem2proc_transaction_tag != 0)
            m_owner[mem2proc_transaction_tag] = e_grant_d ? 1 : 0;
        if (Icache2mem_command != MEM_NONE && !e_grant_i)
            m_losses = (m_losses < STARVE_LIMIT) ? m_losses + 1 : STARVE_LIMIT;
        else
            m_losses = 0;
    endtask

    task automatic drive(input MEM_COMMAND ic, input ADDR ia, input MEM_COMMAND dc,
                         input ADDR da, input MEM_BLOCK dd, input MEM_TAG tt,
                         input MEM_BLOCK rd, input MEM_TAG rt);
        Icache2mem_command = ic; Icache2mem_addr = ia;
        Dcache2mem_command = dc; Dcache2mem_addr = da; Dcache2mem_data = dd;
        mem2proc_transaction_tag = tt; mem2proc_data = rd; mem2proc_data_tag = rt;
    endtask

    task automatic settle();
        @(negedge clock);
        model_eval();
    endtask

    task automatic cycle_end();
        @(posedge clock);
        model_commit();
        #1;
    endtask

    task automatic idle_cycle();
        drive(MEM_NONE, 0, MEM_NONE, 0, 0, 0, 0, 0);
        settle();
        cycle_end();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(MEM_LOAD, 32'h40, MEM_STORE, 32'h80, 64'h55, 4'd6, 64'h77, 4'd6);
        settle();
        if (proc2mem_command !== MEM_NONE) begin errors++; $display("FAIL reset_cmd got %0d exp 0", proc2mem_command); end
        checks++;
        if (dcache_request !== 1'b0) begin errors++; $display("FAIL reset_dreq got %0b exp 0", dcache_request); end
        checks++;
        if ({mem2Icache_transaction_tag, mem2Dcache_transaction_tag, mem2Icache_data_tag, mem2Dcache_data_tag} !== 16'h0) begin
            errors++; $display("FAIL reset_tags got %h exp 0", {mem2Icache_transaction_tag, mem2Dcache_transaction_tag, mem2Icache_data_tag, mem2Dcache_data_tag});
        end
        checks++;
        cycle_end();
        reset = 1'b0;
    endtask

    task automatic test_icache_load();
        do_reset();
        drive(MEM_LOAD, 32'h100, MEM_NONE, 0, 0, 4'd3, 0, 0);
        settle();
        if (proc2mem_addr !== 32'h100) begin errors++; $display("FAIL ic_addr got %h exp 100", proc2mem_addr); end
        checks++;
        if (mem2Icache_transaction_tag !== 4'd3) begin errors++; $display("FAIL ic_ttag got %0d exp 3", mem2Icache_transaction_tag); end
        checks++;
        cycle_end();
        idle_cycle();
        drive(MEM_NONE, 0, MEM_NONE, 0, 0, 0, 64'hDEAD, 4'd3);
        settle();
        if (mem2Icache_data_tag !== 4'd3 || mem2Dcache_data_tag !== 4'd0) begin
            errors++; $display("FAIL ic_return got i=%0d d=%0d exp i=3 d=0", mem2Icache_data_tag, mem2Dcache_data_tag);
        end
        checks++;
        if (mem2Icache_data !== 64'hDEAD) begin errors++; $display("FAIL ic_data got %h exp dead", mem2Icache_data); end
        checks++;
        cycle_end();
    endtask

    task automatic test_starvation();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            logic exp_d;
            drive(MEM_LOAD, 32'h1000 + c, MEM_LOAD, 32'h2000 + c, 0, MEM_TAG'(c + 1), 0, 0);
            settle();
            exp_d = !(c == 4 || c == 9);
            if (dcache_request !== exp_d) begin errors++; $display("FAIL starve_dreq cyc %0d got %0b exp %0b", c, dcache_request, exp_d); end
            checks++;
            if (proc2mem_addr !== (exp_d ? 32'h2000 + c : 32'h1000 + c)) begin
                errors++; $display("FAIL starve_addr cyc %0d got %h", c, proc2mem_addr);
            end
            checks++;
            cycle_end();
        end
    endtask

    task automatic test_store();
        do_reset();
        drive(MEM_NONE, 0, MEM_STORE, 32'h200, 64'hAB, 4'd5, 0, 0);
        settle();
        if (proc2mem_data !== 64'hAB || proc2mem_command !== MEM_STORE) begin
            errors++; $display("FAIL st_bus got data=%h cmd=%0d exp ab/2", proc2mem_data, proc2mem_command);
        end
        checks++;
        if (mem2Dcache_transaction_tag !== 4'd5) begin errors++; $display("FAIL st_ttag got %0d exp 5", mem2Dcache_transaction_tag); end
        checks++;
        cycle_end();
        drive(MEM_NONE, 0, MEM_NONE, 0, 0, 0, 64'h99, 4'd5);
        settle();
        if (mem2Icache_data_tag !== 4'd0 || mem2Dcache_data_tag !== 4'd0) begin
            errors++; $display("FAIL st_drop got i=%0d d=%0d exp 0/0", mem2Icache_data_tag, mem2Dcache_data_tag);
        end
        checks++;
        cycle_end();
    endtask

    task automatic test_reject();
        do_reset();
        drive(MEM_LOAD, 32'h300, MEM_NONE, 0, 0, 4'd9, 0, 0);
        settle();
        cycle_end();
        for (int c = 0; c < 2; c++) begin
            drive(MEM_LOAD, 32'h304, MEM_LOAD, 32'h400, 0, 4'd0, 0, 0);
            settle();
            cycle_end();
        end
        drive(MEM_LOAD, 32'h308, MEM_NONE, 0, 0, 4'd0, 0, 0);
        settle();
        if (mem2Icache_transaction_tag !== 4'd0 || proc2mem_command !== MEM_LOAD) begin
            errors++; $display("FAIL rej_ttag got tag=%0d cmd=%0d exp 0/1", mem2Icache_transaction_tag, proc2mem_command);
        end
        checks++;
        cycle_end();
        for (int c = 0; c < 5; c++) begin
            drive(MEM_LOAD, 32'h30C, MEM_LOAD, 32'h404, 0, 4'd0, 0, 0);
            settle();
            if (dcache_request !== (c < 4)) begin errors++; $display("FAIL rej_starve cyc %0d got %0b exp %0b", c, dcache_request, c < 4); end
            checks++;
            cycle_end();
        end
        drive(MEM_NONE, 0, MEM_NONE, 0, 0, 0, 64'h1, 4'd9);
        settle();
        if (mem2Icache_data_tag !== 4'd9) begin errors++; $display("FAIL rej_table got %0d exp 9", mem2Icache_data_tag); end
        checks++;
        cycle_end();
    endtask

    task automatic test_same_tag();
        do_reset();
        drive(MEM_LOAD, 32'h500, MEM_NONE, 0, 0, 4'd7, 0, 0);
        settle();
        cycle_end();
        drive(MEM_NONE, 0, MEM_LOAD, 32'h600, 0, 4'd7, 64'h70, 4'd7);
        settle();
        if (mem2Icache_data_tag !== 4'd7 || mem2Dcache_data_tag !== 4'd0) begin
            errors++; $display("FAIL same_old got i=%0d d=%0d exp 7/0", mem2Icache_data_tag, mem2Dcache_data_tag);
        end
        checks++;
        if (mem2Dcache_transaction_tag !== 4'd7) begin errors++; $display("FAIL same_ttag got %0d exp 7", mem2Dcache_transaction_tag); end
        checks++;
        cycle_end();
        drive(MEM_NONE, 0, MEM_NONE, 0, 0, 0, 64'h71, 4'd7);
        settle();
        if (mem2Dcache_data_tag !== 4'd7 || mem2Icache_data_tag !== 4'd0) begin
            errors++; $display("FAIL same_new got i=%0d d=%0d exp 0/7", mem2Icache_data_tag, mem2Dcache_data_tag);
        end
        checks++;
        cycle_end();
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(MEM_NONE, 0, MEM_LOAD, 32'h700, 0, 4'd2, 0, 0);
        settle();
        cycle_end();
        reset = 1'b1;
        drive(MEM_LOAD, 32'h704, MEM_LOAD, 32'h708, 64'h3, 4'd4, 64'h2, 4'd2);
        settle();
        if (proc2mem_command !== MEM_NONE || mem2Dcache_data_tag !== 4'd0 || mem2Dcache_transaction_tag !== 4'd0) begin
            errors++; $display("FAIL rmid_inactive got cmd=%0d dtag=%0d ttag=%0d exp 0", proc2mem_command, mem2Dcache_data_tag, mem2Dcache_transaction_tag);
        end
        checks++;
        cycle_end();
        reset = 1'b0;
        drive(MEM_NONE, 0, MEM_NONE, 0, 0, 0, 64'h2, 4'd2);
        settle();
        if (mem2Icache_data_tag !== 4'd0 || mem2Dcache_data_tag !== 4'd0) begin
            errors++; $display("FAIL rmid_drop got i=%0d d=%0d exp 0/0", mem2Icache_data_tag, mem2Dcache_data_tag);
        end
        checks++;
        cycle_end();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            MEM_COMMAND ic, dc;
            MEM_TAG tt;
            ic = ($urandom_range(0, 3) == 0) ? MEM_NONE : MEM_LOAD;
            case ($urandom_range(0, 2))
                0:       dc = MEM_NONE;
                1:       dc = MEM_LOAD;
                default: dc = MEM_STORE;
            endcase
            tt = ($urandom_range(0, 3) == 0) ? 4'd0 : MEM_TAG'($urandom_range(1, 15));
            reset = ($urandom_range(0, 39) == 0);
            drive(ic, $urandom, dc, $urandom, {$urandom, $urandom}, tt,
                  {$urandom, $urandom}, MEM_TAG'($urandom_range(0, 15)));
            settle();
            if (proc2mem_command !== e_cmd) begin errors++; $display("FAIL rnd_cmd cyc %0d got %0d exp %0d", c, proc2mem_command, e_cmd); end
            checks++;
            if (proc2mem_addr !== e_addr) begin errors++; $display("FAIL rnd_addr cyc %0d got %h exp %h", c, proc2mem_addr, e_addr); end
            checks++;
            if (proc2mem_data !== e_pdata) begin errors++; $display("FAIL rnd_pdata cyc %0d got %h exp %h", c, proc2mem_data, e_pdata); end
            checks++;
            if (dcache_request !== e_dreq) begin errors++; $display("FAIL rnd_dreq cyc %0d got %0b exp %0b", c, dcache_request, e_dreq); end
            checks++;
            if (mem2Icache_transaction_tag !== e_itag || mem2Dcache_transaction_tag !== e_dtag) begin
                errors++; $display("FAIL rnd_ttag cyc %0d got i=%0d d=%0d exp i=%0d d=%0d", c, mem2Icache_transaction_tag, mem2Dcache_transaction_tag, e_itag, e_dtag);
            end
            checks++;
            if (mem2Icache_data_tag !== e_idtag || mem2Dcache_data_tag !== e_ddtag) begin
                errors++; $display("FAIL rnd_dtag cyc %0d got i=%0d d=%0d exp i=%0d d=%0d", c, mem2Icache_data_tag, mem2Dcache_data_tag, e_idtag, e_ddtag);
            end
            checks++;
            if (mem2Icache_data !== e_data || mem2Dcache_data !== e_data) begin
                errors++; $display("FAIL rnd_data cyc %0d got i=%h d=%h exp %h", c, mem2Icache_data, mem2Dcache_data, e_data);
            end
            checks++;
            cycle_end();
        end
        reset = 1'b0;
    endtask

    initial begin
        foreach (m_owner[i]) m_owner[i] = -1;
        m_losses = 0;
        reset = 1'b1;
        drive(MEM_NONE, 0, MEM_NONE, 0, 0, 0, 0, 0);
        test_reset();
        test_icache_load();
        test_starvation();
        test_store();
        test_reject();
        test_same_tag();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single memory port between the instruction cache (fetch stage) and the data cache. Each cycle it grants at most one requester onto the bus and records which requester owns each accepted memory tag. It then steers returning data blocks back to the owning cache. Its `dcache_request` output drives the icache's `dcache_request` input, so the icache knows it lost arbitration this cycle.

Parameters:
NUM_TAGS, `NUM_MEM_TAGS (15), number of nonzero memory tags tracked; tag 0 means "no transaction".
STARVE_LIMIT, 4, consecutive icache losses after which the icache gets priority for one grant.

Ports:
clock  in  1  system clock, single clock domain
reset  in  1  synchronous, active-high reset
Icache2mem_command  in  MEM_COMMAND  icache request; MEM_NONE means idle (MEM_LOAD only)
Icache2mem_addr  in  ADDR  icache request address
Dcache2mem_command  in  MEM_COMMAND  dcache request (MEM_NONE/MEM_LOAD/MEM_STORE)
Dcache2mem_addr  in  ADDR  dcache request address
Dcache2mem_data  in  MEM_BLOCK  dcache store data
mem2proc_transaction_tag  in  MEM_TAG  acceptance tag for the current bus request; 0 means rejected
mem2proc_data  in  MEM_BLOCK  returning data block
mem2proc_data_tag  in  MEM_TAG  tag of the returning data; 0 means none
proc2mem_command  out  MEM_COMMAND  granted command to memory
proc2mem_addr  out  ADDR  granted address
proc2mem_data  out  MEM_BLOCK  store data (dcache grant only), else 0
mem2Icache_transaction_tag  out  MEM_TAG  acceptance tag for icache; 0 if not granted or rejected
mem2Icache_data  out  MEM_BLOCK  data to icache
mem2Icache_data_tag  out  MEM_TAG  returning tag for icache; 0 if not icache-owned
mem2Dcache_transaction_tag  out  MEM_TAG  acceptance tag for dcache
mem2Dcache_data  out  MEM_BLOCK  data to dcache
mem2Dcache_data_tag  out  MEM_TAG  returning tag for dcache
dcache_request  out  1  dcache holds the bus this cycle (icache request blocked)

Behaviour:
- Interface: one clock, `clock`. Reset `reset` is synchronous and active-high. In the reset cycle all outputs are forced inactive: commands MEM_NONE, all tags 0, `dcache_request` 0.
- State:
  - `owner_valid[1..NUM_TAGS]` and `owner_is_dcache[1..NUM_TAGS]`, all cleared on reset.
  - `starve_cnt`, range 0..STARVE_LIMIT, cleared on reset.
- Grant (combinational, 0-cycle latency):
  - Only one side active: grant it.
  - Both active: grant dcache unless `starve_cnt == STARVE_LIMIT`, in which case grant icache.
  - Neither active: `proc2mem_command` is MEM_NONE.
  - `dcache_request` = dcache granted.
- Acceptance:
  - The granted side receives `mem2proc_transaction_tag` on its transaction_tag output.
  - The losing side receives 0 and must retry; the arbiter keeps no queue.
  - Tag 0 from memory means rejected; no state change.
- Owner table update:
  - Recorded at the clock edge when a load is accepted (nonzero tag): set `owner_valid[tag]` and set `owner_is_dcache[tag]` to the granted side.
  - Accepted stores are not recorded.
  - Accepting a tag whose `owner_valid` is already set overwrites the entry.
- Data return (combinational from registered table):
  - `mem2proc_data_tag` nonzero and its owner entry valid: drive data and tag to the owner only; the other side's data_tag is 0.
  - That entry is cleared at the clock edge.
  - Unknown tag (entry not valid): dropped, both data_tags 0.
  - Data outputs mirror `mem2proc_data` to both sides; the tag qualifies them.
- Simultaneous return and accept of the same tag in one cycle: the return is routed using the old owner, then the new allocation takes effect (set beats clear).
- `starve_cnt`:
  - Increments, saturating, when the icache requests and is not granted.
  - Resets to 0 when the icache is granted or the icache is idle.
  - Grant counts, not acceptance.
- Reset mid-operation: all outstanding tags are forgotten; later returns with those tags are dropped.
- Command values pass through unchanged. Widths come from the codebase types (ADDR 32, MEM_BLOCK 64, MEM_TAG 4).

Test Plan:
- Only icache LOAD 0x100, memory tag 3 → `proc2mem_addr` = 0x100, `mem2Icache_transaction_tag` = 3. Later data_tag 3, data 0xDEAD → `mem2Icache_data_tag` = 3, `mem2Dcache_data_tag` = 0.
- Both request every cycle, memory always accepts, STARVE_LIMIT = 4 → dcache granted cycles 0-3, icache granted cycle 4, then dcache for cycles 5-8, icache at 9.
- Dcache STORE 0x200 with data 0xAB, tag 5 → `proc2mem_data` = 0xAB, dcache sees tag 5. A later data_tag 5 is dropped (both data_tags 0).
- Memory rejects (tag 0) an icache load → icache transaction_tag 0, table unchanged, `starve_cnt` reset to 0.
- Tag 7 owned by icache returns in the same cycle that a dcache load is accepted with tag 7 → icache receives tag 7 this cycle. The next return of tag 7 goes to the dcache.
- Dcache load accepted with tag 2, then reset asserted, then data_tag 2 returns → both data_tags 0. All outputs are inactive during the reset cycle.
